// File: rtl/dsc_cache_rd_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dsc_cache_rd_arbiter_pkg
// Shared types and helpers for the descriptor cache read arbiter.
//   - Default parameter constants for the arbiter.
//   - tag_stage_t: one stage of the read-tag pipeline {valid, one-hot id}.
//   - first_set(): priority encoder used by the round-robin picker.
// -----------------------------------------------------------------------------
package dsc_cache_rd_arbiter_pkg;

  localparam int MAX_REQ        = 8;
  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_ADDR_WIDTH = 7;
  localparam int DEF_DATA_WIDTH = 128;
  localparam int DEF_RD_LATENCY = 2;

  // The id field is sized for the largest supported requester count so the
  // struct can live here. Builds with fewer requesters leave the upper bits zero.
  typedef struct packed {
    logic               valid;
    logic [MAX_REQ-1:0] id;
  } tag_stage_t;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } pick_t;

  // Returns the lowest set bit of v.
  function automatic pick_t first_set(input logic [MAX_REQ-1:0] v);
    pick_t p;
    p = '0;
    for (int i = MAX_REQ - 1; i >= 0; i--) begin
      if (v[i]) begin
        p.found = 1'b1;
        p.idx   = 3'(i);
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/dsc_cache_rd_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// dsc_cache_rr_pick
// Combinational round-robin picker: the request vector is rotated so that
// index ptr lands at bit 0, priority-encoded, and the winner is unrotated.
// Ports:
//   req  in  NUM_REQ          request vector
//   ptr  in  $clog2(NUM_REQ)  highest-priority index this cycle
//   gnt  out NUM_REQ          one-hot winner (zero when no request)
//   idx  out $clog2(NUM_REQ)  winner index
//   any  out 1                at least one request present
// -----------------------------------------------------------------------------
module dsc_cache_rr_pick
  import dsc_cache_rd_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] idx,
  output logic                       any
);

  localparam int              PTR_W = $clog2(NUM_REQ);
  localparam logic [PTR_W:0]  N_W   = (PTR_W + 1)'(NUM_REQ);

  logic [MAX_REQ-1:0] rot;
  pick_t              p;
  logic [PTR_W:0]     sum;

  // NOTE: every variable written here gets a default before any conditional
  // assignment, so no path leaves a value held and no latch is inferred.
  always_comb begin
    rot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      int j;
      j = i + int'(ptr);
      if (j >= NUM_REQ) j = j - NUM_REQ;
      rot[i] = req[j];
    end
    p   = first_set(rot);
    // Unrotate: winner = (ptr + offset) mod NUM_REQ, with offset < NUM_REQ.
    sum = {1'b0, ptr} + (PTR_W + 1)'(p.idx);
    if (sum >= N_W) sum = sum - N_W;
    idx = sum[PTR_W-1:0];
    any = p.found;
    gnt = '0;
    if (p.found) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/dsc_cache_rd_arbiter.sv
// -----------------------------------------------------------------------------
// dsc_cache_rd_arbiter
// Shares the descriptor cache RAM read port between NUM_REQ channel engines
// with round-robin arbitration, passes the descriptor-fetch write stream to the
// RAM write port, and routes read data back through a tag pipeline matched to
// the RAM read latency.
// Optional feature: define CDMA_DSC_ARB_WR_HAZARD_EN to stall a read whose
// address matches a same-cycle write, so returned data is always post-write.
// Ports:
//   clock, reset_n             clock, synchronous active-low reset
//   req_valid/req_addr/req_ready  read request handshake (one-hot ready)
//   rsp_valid/rsp_data         one-hot response valid, shared data
//   wr_valid/wr_addr/wr_data   write stream in
//   ram_wen/ram_waddr/ram_wdata   RAM write port
//   ram_ren/ram_raddr/ram_rdata   RAM read port
//   busy                       a read is in flight
// -----------------------------------------------------------------------------
module dsc_cache_rd_arbiter
  import dsc_cache_rd_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int RD_LATENCY = DEF_RD_LATENCY
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  input  logic                          wr_valid,
  input  logic [ADDR_WIDTH-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  output logic                          ram_wen,
  output logic [ADDR_WIDTH-1:0]         ram_waddr,
  output logic [DATA_WIDTH-1:0]         ram_wdata,
  output logic                          ram_ren,
  output logic [ADDR_WIDTH-1:0]         ram_raddr,
  input  logic [DATA_WIDTH-1:0]         ram_rdata,
  output logic                          busy
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]      rr_ptr;
  logic [NUM_REQ-1:0]    cand_gnt;
  logic [PTR_W-1:0]      cand_idx;
  logic                  cand_any;
  logic [ADDR_WIDTH-1:0] cand_addr;
  logic                  hazard;
  logic                  grant;
  logic [MAX_REQ-1:0]    grant_id;
  logic                  busy_any;
  tag_stage_t            stage [RD_LATENCY];
  logic                  unused_id_hi;

  // Write path is a pure pass-through and never stalls.
  assign ram_wen   = wr_valid;
  assign ram_waddr = wr_addr;
  assign ram_wdata = wr_data;

  dsc_cache_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (cand_gnt),
    .idx (cand_idx),
    .any (cand_any)
  );

  assign cand_addr = req_addr[int'(cand_idx)*ADDR_WIDTH +: ADDR_WIDTH];

`ifdef CDMA_DSC_ARB_WR_HAZARD_EN
  // A colliding candidate blocks the whole cycle; nobody else is granted and
  // the pointer holds, so the same requester wins once the write has landed.
  assign hazard = wr_valid && (cand_addr == wr_addr);
`else
  assign hazard = 1'b0;
`endif

  assign grant     = reset_n && cand_any && !hazard;
  assign req_ready = grant ? cand_gnt : '0;
  assign ram_ren   = grant;
  assign ram_raddr = cand_addr;

  always_comb begin
    grant_id                = '0;
    grant_id[NUM_REQ-1:0]   = req_ready;
  end

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples the previous stage's pre-edge value and the pipeline shifts cleanly.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rr_ptr <= '0;
    end else if (grant) begin
      rr_ptr <= (int'(cand_idx) == NUM_REQ - 1) ? '0 : cand_idx + 1'b1;
    end
  end

  // NOTE: the tag stages are control state and must be cleared on reset so
  // reads in flight are dropped; the RAM data path itself needs no reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < RD_LATENCY; i++) stage[i] <= '0;
    end else begin
      stage[0] <= '{valid: grant, id: grant_id};
      for (int i = 1; i < RD_LATENCY; i++) stage[i] <= stage[i-1];
    end
  end

  always_comb begin
    busy_any = 1'b0;
    for (int i = 0; i < RD_LATENCY; i++) busy_any = busy_any | stage[i].valid;
  end

  // Outputs are gated with reset_n so they read inactive for the whole time
  // reset is held, including before the first clock edge.
  assign busy      = reset_n && busy_any;
  assign rsp_valid = (reset_n && stage[RD_LATENCY-1].valid)
                   ? stage[RD_LATENCY-1].id[NUM_REQ-1:0] : '0;
  assign rsp_data  = ram_rdata;

  // Upper id bits are always zero when NUM_REQ < MAX_REQ.
  assign unused_id_hi = |(stage[RD_LATENCY-1].id >> NUM_REQ);

endmodule

// File: tb/tb_dsc_cache_rd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dsc_cache_rd_arbiter
// Directed and randomized stimulus for dsc_cache_rd_arbiter with a reference
// model of the arbitration rules and a response scoreboard. A behavioural RAM
// with registered address and registered data (two-cycle latency) sits on the
// RAM ports. Honours CDMA_DSC_ARB_WR_HAZARD_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_dsc_cache_rd_arbiter;

  localparam int NR = 4;
  localparam int AW = 7;
  localparam int DW = 128;
  localparam int LAT = 2;

  logic           clock = 1'b0;
  logic           reset_n;
  logic [NR-1:0]  req_valid;
  logic [AW-1:0]  a [NR];
  logic [NR*AW-1:0] req_addr;
  logic [NR-1:0]  req_ready;
  logic [NR-1:0]  rsp_valid;
  logic [DW-1:0]  rsp_data;
  logic           wr_valid;
  logic [AW-1:0]  wr_addr;
  logic [DW-1:0]  wr_data;
  logic           ram_wen;
  logic [AW-1:0]  ram_waddr;
  logic [DW-1:0]  ram_wdata;
  logic           ram_ren;
  logic [AW-1:0]  ram_raddr;
  logic [DW-1:0]  ram_rdata;
  logic           busy;

  assign req_addr = {a[3], a[2], a[1], a[0]};

  dsc_cache_rd_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(LAT)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .wr_valid  (wr_valid),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .ram_wen   (ram_wen),
    .ram_waddr (ram_waddr),
    .ram_wdata (ram_wdata),
    .ram_ren   (ram_ren),
    .ram_raddr (ram_raddr),
    .ram_rdata (ram_rdata),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Behavioural RAM: address registered on the read cycle, data registered
  // on the next edge.
  logic [DW-1:0] mem [1 << AW];
  logic [AW-1:0] raddr_q = '0;
  logic [DW-1:0] rdata_q = '0;
  always @(posedge clock) begin
    if (ram_wen) mem[ram_waddr] <= ram_wdata;
    if (ram_ren) raddr_q <= ram_raddr;
    rdata_q <= mem[raddr_q];
  end
  assign ram_rdata = rdata_q;

  // Reference model state.
  typedef struct {
    int            due;
    logic [NR-1:0] id;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          q [$];
  logic [DW-1:0] shadow [1 << AW];
  int            ptr;
  int            n_tests = 0;
  int            n_fail  = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // One clock cycle of stimulus. g returns the model's grant index, -1 if none.
  task automatic step(input logic [NR-1:0] v,
                      input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                      input logic [AW-1:0] a2, input logic [AW-1:0] a3,
                      input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      output int g);
    logic [AW-1:0] ad [NR];
    logic [NR-1:0] exp_rdy;
    @(posedge clock);
    #1;
    req_valid = v;
    a[0] = a0; a[1] = a1; a[2] = a2; a[3] = a3;
    wr_valid = wv; wr_addr = wa; wr_data = wd;
    ad[0] = a0; ad[1] = a1; ad[2] = a2; ad[3] = a3;
    #1;
    g = -1;
    for (int k = 0; k < NR; k++) begin
      if (g < 0 && v[(ptr + k) % NR]) g = (ptr + k) % NR;
    end
`ifdef CDMA_DSC_ARB_WR_HAZARD_EN
    if (g >= 0 && wv && ad[g] == wa) g = -1;
`endif
    exp_rdy = (g >= 0) ? NR'(1 << g) : '0;
    check("req_ready", DW'(req_ready), DW'(exp_rdy));
    check("ram_ren", DW'(ram_ren), DW'(g >= 0));
    if (g >= 0) check("ram_raddr", DW'(ram_raddr), DW'(ad[g]));
    check("ram_wen", DW'(ram_wen), DW'(wv));
    if (wv) begin
      check("ram_waddr", DW'(ram_waddr), DW'(wa));
      check("ram_wdata", ram_wdata, wd);
      shadow[wa] = wd;
    end
    if (g >= 0) begin
      q.push_back('{due: cyc + LAT, id: exp_rdy, data: shadow[ad[g]]});
      ptr = (g + 1) % NR;
    end
  endtask

  task automatic idle(input int n);
    int g;
    for (int i = 0; i < n; i++) step('0, '0, '0, '0, '0, 1'b0, '0, '0, g);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      reset_n   = 1'b0;
      req_valid = '1;
      wr_valid  = 1'b0;
      #1;
      q.delete();
      ptr = 0;
      check("rst_req_ready", DW'(req_ready), '0);
      check("rst_ram_ren", DW'(ram_ren), '0);
      check("rst_rsp_valid", DW'(rsp_valid), '0);
      check("rst_busy", DW'(busy), '0);
    end
    @(posedge clock);
    #1;
    reset_n   = 1'b1;
    req_valid = '0;
  endtask

  // Scoreboard monitor: samples on the falling edge.
  always @(negedge clock) begin
    logic busy_exp;
    busy_exp = 1'b0;
    foreach (q[k]) if (q[k].due - LAT < cyc) busy_exp = 1'b1;
    check("busy", DW'(busy), DW'(busy_exp));
    if (q.size() > 0 && q[0].due == cyc) begin
      check("rsp_valid", DW'(rsp_valid), DW'(q[0].id));
      check("rsp_data", rsp_data, q[0].data);
      void'(q.pop_front());
    end else if (rsp_valid !== '0) begin
      check("rsp_valid_unexpected", DW'(rsp_valid), '0);
    end
  end

  initial begin
    int g;
    logic [NR-1:0]  pend;
    logic [AW-1:0]  pa [NR];
    logic           wv;
    logic [AW-1:0]  wa;
    logic [DW-1:0]  wd;

    reset_n = 1'b0; req_valid = '1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    for (int i = 0; i < NR; i++) a[i] = '0;
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i]    = {4{32'(i) * 32'h0101_0101 ^ 32'hC3A5_0F00}};
      shadow[i] = {4{32'(i) * 32'h0101_0101 ^ 32'hC3A5_0F00}};
    end
    ptr = 0;

    // Reset with all requests asserted.
    do_reset(3);

    // Fairness from reset: continuous requests rotate 0,1,2,3,0,...
    for (int k = 0; k < 8; k++) begin
      step(4'b1111, 7'd20, 7'd21, 7'd22, 7'd23, 1'b0, '0, '0, g);
      check("fair_order", DW'(g), DW'(k % NR));
    end
    idle(3);

    // Single read after write: req1 reads address 3.
    step('0, '0, '0, '0, '0, 1'b1, 7'd3, {16{8'h5A}}, g);
    step(4'b0010, '0, 7'd3, '0, '0, 1'b0, '0, '0, g);
    check("single_grant", DW'(g), DW'(1));
    idle(3);

    // Sparse wrap: grant req2 to move pointer to 3, then req0 then req2.
    step(4'b0100, '0, '0, 7'd40, '0, 1'b0, '0, '0, g);
    check("wrap_setup", DW'(g), DW'(2));
    step(4'b0101, 7'd41, '0, 7'd42, '0, 1'b0, '0, '0, g);
    check("wrap_first", DW'(g), DW'(0));
    step(4'b0100, '0, '0, 7'd42, '0, 1'b0, '0, '0, g);
    check("wrap_second", DW'(g), DW'(2));
    idle(3);

    // Same-cycle write and read of address 9 (pointer now 3, req0 next).
    step(4'b0011, 7'd9, 7'd5, '0, '0, 1'b1, 7'd9, {4{32'hFEED_0009}}, g);
`ifdef CDMA_DSC_ARB_WR_HAZARD_EN
    check("hazard_stall", DW'(g), DW'(-1));
    step(4'b0011, 7'd9, 7'd5, '0, '0, 1'b0, '0, '0, g);
    check("hazard_retry", DW'(g), DW'(0));
`else
    check("no_hazard_grant", DW'(g), DW'(0));
`endif
    step(4'b0010, '0, 7'd5, '0, '0, 1'b0, '0, '0, g);
    check("hazard_after", DW'(g), DW'(1));
    idle(3);

    // Reset one cycle after a grant: the response must never appear.
    step(4'b1000, '0, '0, '0, 7'd77, 1'b0, '0, '0, g);
    check("midflight_grant", DW'(g), DW'(3));
    do_reset(1);
    idle(4);

    // Randomized traffic; requesters hold their request until granted.
    pend = '0;
    for (int i = 0; i < NR; i++) pa[i] = '0;
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NR; i++) begin
        if (!pend[i] && ($urandom % 3 == 0)) begin
          pend[i] = 1'b1;
          pa[i]   = AW'($urandom % 16);
        end
      end
      wv = 1'($urandom % 2);
      wa = AW'($urandom % 16);
      wd = {$urandom, $urandom, $urandom, $urandom};
      step(pend, pa[0], pa[1], pa[2], pa[3], wv, wa, wd, g);
      if (g >= 0) pend[g] = 1'b0;
    end
    idle(LAT + 3);
    check("drain_empty", DW'(q.size()), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
